// File: rtl/mult_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_pkg -- shared FSM encoding and default width for the MULT/DIV unit
// Rev 1.0
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_e;

endpackage
`default_nettype wire

// File: rtl/iter_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iter_multiplier -- radix-2 shift-add multiplier, signed/unsigned, WIDTH+1 latency
// Rev 1.0
// ---------------------------------------------------------------------------
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mult_state_e        state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] product;

  // Magnitudes are taken unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) fits exactly.
  always_comb begin
    a_mag    = (is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    b_mag    = (is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
    step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    product  = {acc_hi, acc_lo};
  end

  // acc_lo starts as the multiplier; product bits shift in from the top as it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            acc_lo <= b_mag;
            acc_hi <= '0;
            count  <= '0;
            neg    <= (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed;
            state  <= CALC;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          acc_hi <= step_sum[WIDTH:1];
          acc_lo <= {step_sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + CNT_ONE;
          if (count == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          {hi, lo} <= neg ? ({(2*WIDTH){1'b0}} - product) : product;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_multiplier.sv
`timescale 1ns/1ps
// tb_iter_multiplier -- directed checks of the iterative multiplier at WIDTH 32 and 8.
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, flush = 1'b0, is_signed = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0, flush8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  iter_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .flush(flush8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until done is seen, or max+1 if it never appears.
  task automatic wait_done(input bit use8, input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = max + 1;
    for (int i = 1; i <= max && !seen; i++) begin
      tick();
      if (use8 ? done8 : done) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  task automatic run32(input string tag, input logic sg, input logic [31:0] va,
                       input logic [31:0] vb, input logic [63:0] exp);
    int n;
    is_signed = sg; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~sg;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(1'b0, 40, n);
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_prod"}, {hi, lo}, exp);
    tick();
    check({tag, "_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run8(input string tag, input logic sg, input logic [7:0] va,
                      input logic [7:0] vb, input logic [15:0] exp);
    int n;
    sgn8 = sg; a8 = va; b8 = vb; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; sgn8 = ~sg;
    wait_done(1'b1, 20, n);
    check({tag, "_lat"}, 64'(n), 64'd9);
    check({tag, "_prod"}, {48'd0, hi8, lo8}, {48'd0, exp});
    tick();
    check({tag, "_pulse"}, {63'd0, done8}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, cnt;
    logic [31:0] ra, rb;
    logic        sg;
    logic [63:0] ea, eb;

    reset = 1'b1;
    tick(); tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    run32("u_max",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run32("s_m3x7",   1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
    run32("u_m3x7",   1'b0, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB);
    run32("s_minsq",  1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run32("s_maxmin", 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000);
    run32("s_m1m1",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    run32("u_zero",   1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; sg = (i % 2) == 1;
      ea = sg ? {{32{ra[31]}}, ra} : {32'd0, ra};
      eb = sg ? {{32{rb[31]}}, rb} : {32'd0, rb};
      run32("rand", sg, ra, rb, ea * eb);
    end

    // start pulsed mid-operation must not disturb the accepted one
    is_signed = 1'b0; a = 32'd2; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    a = 32'd7; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, 40, n);
    check("busy_ign_lat", 64'(n), 64'd27);
    check("busy_ign_prod", {hi, lo}, 64'd4);
    tick();

    // start held high: DONE must not accept it, so the gap is WIDTH+3
    is_signed = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    wait_done(1'b0, 40, n);
    check("b2b_lat", 64'(n), 64'd33);
    check("b2b_prod1", {hi, lo}, 64'd15);
    wait_done(1'b0, 40, n);
    check("b2b_gap", 64'(n), 64'd35);
    check("b2b_prod2", {hi, lo}, 64'd15);
    start = 1'b0;
    count_done(40, cnt);
    check("b2b_extra", 64'(cnt), 64'd0);
    check("b2b_idle", {63'd0, busy}, 64'd0);

    // flush with simultaneous start on the 10th CALC cycle
    run32("pre_flush", 1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
    is_signed = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hold", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    count_done(40, cnt);
    check("flush_nodone", 64'(cnt), 64'd0);
    check("flush_hold2", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run32("post_flush", 1'b0, 32'd5, 32'd5, 64'd25);

    // reset while in FIX discards the operation
    is_signed = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    check("fix_busy", {63'd0, busy}, 64'd1);
    check("fix_done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstfix_busy", {63'd0, busy}, 64'd0);
    check("rstfix_done", {63'd0, done}, 64'd0);
    check("rstfix_hilo", {hi, lo}, 64'd0);
    count_done(40, cnt);
    check("rstfix_nodone", 64'(cnt), 64'd0);
    run32("post_rst", 1'b1, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA);

    // 8-bit instance
    run8("w8_minsq", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("w8_umax",  1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("w8_negx3", 1'b1, 8'h85, 8'h03, 16'hFE8F);
    run8("w8_m1min", 1'b1, 8'hFF, 8'h80, 16'h0080);
    sgn8 = 1'b0; a8 = 8'd12; b8 = 8'd11; start8 = 1'b1;
    tick();
    wait_done(1'b1, 20, n);
    check("w8_b2b_lat", 64'(n), 64'd9);
    wait_done(1'b1, 20, n);
    check("w8_b2b_gap", 64'(n), 64'd11);
    check("w8_b2b_prod", {48'd0, hi8, lo8}, 64'd132);
    start8 = 1'b0;
    tick(); tick();
    check("w8_idle", {63'd0, busy8}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_multiplier.md
ITER_MULTIPLIER -- requirements
Module: iter_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port flush  input  1  pipeline squash; abandons any operation in flight.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port a  input  WIDTH  multiplicand, captured with start.
REQ-008 SHALL have port b  input  WIDTH  multiplier, captured with start.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  single-cycle pulse: hi/lo hold a new result.
REQ-011 SHALL have port hi  output  WIDTH  upper half of the 2*WIDTH-bit product.
REQ-012 SHALL have port lo  output  WIDTH  lower half of the 2*WIDTH-bit product.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 IDLE: start=1 and flush=0 at edge k SHALL capture is_signed, |a| and |b| (magnitudes when is_signed=1, raw values otherwise) and the result sign (a[MSB]^b[MSB]) & is_signed; clear the accumulator and the iteration counter; go to CALC.
REQ-015 CALC SHALL do one shift-add step per cycle (add multiplicand if the current multiplier LSB is 1, then shift) for exactly WIDTH cycles (edges k+1..k+WIDTH), then go to FIX.
REQ-016 FIX SHALL, at edge k+WIDTH+1, write the 2*WIDTH-bit two's-complement negation of the magnitude product to {hi,lo} if the result sign is 1, else the magnitude product unchanged; go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle (the cycle after edge k+WIDTH+1), then return to IDLE; fixed latency WIDTH+1 edges from start to done.
REQ-018 The product SHALL be exact modulo 2^(2*WIDTH); the signed case -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) SHALL be representable without overflow.
REQ-019 hi/lo SHALL change only at the FIX edge and SHALL hold their last value in all other states, including IDLE and after a flush.
REQ-020 start asserted while busy=1 SHALL be ignored; no queueing.
REQ-021 start asserted in DONE SHALL be ignored; it is accepted earliest in the following IDLE cycle (back-to-back throughput one result per WIDTH+3 cycles).
REQ-022 flush=1 at any edge SHALL force IDLE at that edge, suppress done, and leave hi/lo unchanged; flush has priority over start in the same cycle.
REQ-023 Changes on a, b, is_signed after capture SHALL NOT affect the in-flight result.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of state, start or flush; reset has priority over flush and start.
REQ-025 Reset during CALC or FIX SHALL discard the operation; no done pulse SHALL follow.

Structure
REQ-026 State enumeration (IDLE, CALC, FIX, DONE) and the default WIDTH constant SHALL live in a shared package mult_pkg, reusable by the divider and the HI/LO forwarding logic.
REQ-027 The block SHALL be a single module; no sub-module is required; the counter width SHALL be derived as clog2(WIDTH)+1 from WIDTH.

Verification
REQ-028 WIDTH=32, is_signed=0, a=0xFFFFFFFF, b=0xFFFFFFFF, start pulse -> done exactly 33 edges later, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 WIDTH=32, is_signed=1, a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); same operands with is_signed=0 -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-030 WIDTH=32, is_signed=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 Start a multiply, assert flush on the 10th CALC cycle with start=1 simultaneously -> IDLE next cycle, no done, hi/lo retain prior result; a fresh start then completes normally.
REQ-032 Assert reset during FIX -> busy=0, hi=lo=0 next cycle, no done pulse; start asserted while busy and in DONE -> ignored, exactly one done per accepted start.
REQ-033 Random regression, WIDTH in {8,32}, both modes, back-to-back starts -> every {hi,lo} matches a reference 2*WIDTH-bit product; busy and done timing match REQ-017 and REQ-021.
